// File: rtl/wb_load_tracker_pkg.sv
// wb_load_tracker_pkg: shared entry type and load funct3 encodings for the writeback load tracker.
package wb_load_tracker_pkg;
    localparam int WBT_OFF_W = 3;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LD  = 3'b011,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101,
        F3_LWU = 3'b110
    } load_f3_e;

    typedef struct packed {
        logic                 regf_we;
        logic [4:0]           rd_addr;
        logic [2:0]           funct3;
        logic [WBT_OFF_W-1:0] offset;
    } wbt_entry_t;

    // ld/lwu only exist on a 64-bit data path
    function automatic logic f3_illegal(input logic [2:0] f3, input int data_w);
        return f3 == 3'b111 || (data_w == 32 && (f3 == F3_LD || f3 == F3_LWU));
    endfunction
endpackage

// File: rtl/wb_load_tracker_load_extend.sv
// wb_load_tracker_load_extend: combinational load data alignment and sign/zero extension.
module wb_load_tracker_load_extend
    import wb_load_tracker_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [2:0]        i_funct3,
    input  logic [OFF_W-1:0]  i_offset,
    input  logic [DATA_W-1:0] i_raw,
    output logic [DATA_W-1:0] o_data,
    output logic              o_illegal
);
    logic [7:0]  w_b;
    logic [15:0] w_h;
    logic [31:0] w_w;

    assign w_b       = 8'(i_raw >> {i_offset, 3'b000});
    assign w_h       = 16'(i_raw >> {i_offset[OFF_W-1:1], 4'b0000});
    assign w_w       = (DATA_W == 64) ? 32'(i_raw >> {i_offset[OFF_W-1], 5'b00000}) : 32'(i_raw);
    assign o_illegal = f3_illegal(i_funct3, DATA_W);

    assign o_data = o_illegal              ? '0 :
                    i_funct3 == F3_LB      ? DATA_W'($signed(w_b)) :
                    i_funct3 == F3_LBU     ? DATA_W'(w_b) :
                    i_funct3 == F3_LH      ? DATA_W'($signed(w_h)) :
                    i_funct3 == F3_LHU     ? DATA_W'(w_h) :
                    i_funct3 == F3_LW      ? DATA_W'($signed(w_w)) :
                    i_funct3 == F3_LWU     ? DATA_W'(w_w) :
                                             i_raw;
endmodule

// File: rtl/wb_load_tracker.sv
// wb_load_tracker: in-order tracker of outstanding dmem requests driving a registered
// register-file write port and a busy-rd scoreboard for load-use stalls.
module wb_load_tracker
    import wb_load_tracker_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 32,
    localparam int OFF_W  = $clog2(DATA_W / 8),
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic              iss_regf_we,
    input  logic [4:0]        iss_rd_addr,
    input  logic [2:0]        iss_funct3,
    input  logic [OFF_W-1:0]  iss_offset,
    input  logic              dmem_resp,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              o_regf_we,
    output logic [4:0]        o_rd_addr,
    output logic [DATA_W-1:0] o_write_data,
    output logic [31:0]       o_busy_rd,
    output logic [CW-1:0]     o_outstanding,
    output logic              o_err
);
    localparam int PW = $clog2(DEPTH);

    wbt_entry_t        r_q [DEPTH];
    logic [PW-1:0]     r_head, r_tail;
    logic [CW-1:0]     r_count;
    logic              r_we, r_err;
    logic [4:0]        r_rd;
    logic [DATA_W-1:0] r_data;
    logic              w_push, w_pop, w_illegal;
    logic [DATA_W-1:0] w_ext;
    logic [31:0]       w_busy;

    // ready comes from the registered count only, so a pop never frees a slot in the same cycle
    assign iss_ready = r_count != CW'(DEPTH);
    assign w_push    = iss_valid & iss_ready;
    assign w_pop     = dmem_resp & (r_count != '0);

    wb_load_tracker_load_extend #(.DATA_W(DATA_W)) u_ext (
        .i_funct3  (r_q[r_head].funct3),
        .i_offset  (r_q[r_head].offset[OFF_W-1:0]),
        .i_raw     (dmem_rdata),
        .o_data    (w_ext),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk)
        if (w_push) r_q[r_tail] <= '{regf_we: iss_regf_we, rd_addr: iss_rd_addr,
                                     funct3: iss_funct3, offset: WBT_OFF_W'(iss_offset)};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_we    <= 1'b0;
            r_rd    <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_tail  <= r_tail + PW'(w_push);
            r_head  <= r_head + PW'(w_pop);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            r_we    <= w_pop & r_q[r_head].regf_we & (r_q[r_head].rd_addr != '0) & ~w_illegal;
            r_err   <= r_err | (dmem_resp & ~w_pop) | (w_pop & w_illegal);
            if (w_pop) begin
                r_rd   <= r_q[r_head].rd_addr;
                r_data <= w_ext;
            end
        end

    // slot i is valid when its distance from head is below count
    always_comb begin
        w_busy = '0;
        for (int i = 0; i < DEPTH; i++)
            if ({1'b0, PW'(i) - r_head} < r_count && r_q[i].regf_we) w_busy[r_q[i].rd_addr] = 1'b1;
        w_busy[0] = 1'b0;
    end

    assign o_regf_we     = r_we;
    assign o_rd_addr     = r_rd;
    assign o_write_data  = r_data;
    assign o_busy_rd     = w_busy;
    assign o_outstanding = r_count;
    assign o_err         = r_err;
endmodule

// File: tb/tb_wb_load_tracker.sv
// tb_wb_load_tracker: directed and random traffic against a queue-based reference model with a writeback scoreboard.
module tb_wb_load_tracker;
    logic        clk = 1'b0, rst_n = 1'b0, iss_valid = 1'b0, iss_regf_we = 1'b0, dmem_resp = 1'b0;
    logic [4:0]  iss_rd_addr = '0;
    logic [2:0]  iss_funct3 = '0;
    logic [1:0]  iss_offset = '0;
    logic [31:0] dmem_rdata = '0;
    logic        iss_ready, o_regf_we, o_err;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_write_data, o_busy_rd;
    logic [2:0]  o_outstanding;

    always #5 clk = ~clk;

    wb_load_tracker #(.DEPTH(4), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_regf_we(iss_regf_we), .iss_rd_addr(iss_rd_addr), .iss_funct3(iss_funct3),
        .iss_offset(iss_offset), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .o_regf_we(o_regf_we), .o_rd_addr(o_rd_addr), .o_write_data(o_write_data),
        .o_busy_rd(o_busy_rd), .o_outstanding(o_outstanding), .o_err(o_err)
    );

    typedef struct {logic we; logic [4:0] rd; logic [2:0] f3; logic [1:0] off;} ent_t;
    typedef struct {int due; logic [4:0] rd; logic [31:0] data;} wr_t;

    ent_t        mq[$];
    wr_t         exp_q[$];
    logic        merr = 1'b0;
    int          cyc = 0, n_vec = 0, n_bad = 0;
    ent_t        me;
    logic [32:0] mx;
    logic        mfull;
    logic [31:0] mbusy;
    wr_t         mw;

    // returns {legal, value}
    function automatic logic [32:0] ref_ext(input logic [2:0] f3, input int off, input logic [31:0] raw);
        int unsigned b, h;
        b = (raw >> (8 * off)) & 32'hFF;
        h = (raw >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return {1'b1, 32'(b >= 128 ? b - 256 : b)};
            3'd1:    return {1'b1, 32'(h >= 32768 ? h - 65536 : h)};
            3'd2:    return {1'b1, raw};
            3'd4:    return {1'b1, 32'(b)};
            3'd5:    return {1'b1, 32'(h)};
            default: return {1'b0, 32'h0};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mq.delete();
            exp_q.delete();
            merr = 1'b0;
        end else begin
            cyc++;
            mfull = mq.size() == 4;
            if (dmem_resp) begin
                if (mq.size() == 0) merr = 1'b1;
                else begin
                    me = mq.pop_front();
                    mx = ref_ext(me.f3, int'(me.off), dmem_rdata);
                    if (!mx[32]) merr = 1'b1;
                    else if (me.we && me.rd != 0) exp_q.push_back('{cyc, me.rd, mx[31:0]});
                end
            end
            if (iss_valid && !mfull) mq.push_back('{iss_regf_we, iss_rd_addr, iss_funct3, iss_offset});
        end

    always @(negedge clk)
        if (rst_n) begin
            mbusy = '0;
            foreach (mq[k]) if (mq[k].we) mbusy[mq[k].rd] = 1'b1;
            mbusy[0] = 1'b0;
            chk("busy_rd", o_busy_rd, mbusy);
            chk("outstanding", 32'(o_outstanding), 32'(mq.size()));
            chk("iss_ready", 32'(iss_ready), 32'(mq.size() != 4));
            chk("err", 32'(o_err), 32'(merr));
            if (o_regf_we) begin
                if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL spurious_write: got rd=%0d data=%h, required no write", o_rd_addr, o_write_data);
                end else begin
                    mw = exp_q.pop_front();
                    chk("wb_rd", 32'(o_rd_addr), 32'(mw.rd));
                    chk("wb_data", o_write_data, mw.data);
                end
            end else if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                mw = exp_q.pop_front();
                n_vec++;
                n_bad++;
                $display("FAIL missing_write: got none, required rd=%0d data=%h", mw.rd, mw.data);
            end
        end

    task automatic cycle(input logic v, input logic we, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] off, input logic r, input logic [31:0] d);
        @(negedge clk);
        iss_valid = v; iss_regf_we = we; iss_rd_addr = rd; iss_funct3 = f3; iss_offset = off;
        dmem_resp = r; dmem_rdata = d;
        @(posedge clk);
        #1;
        iss_valid = 1'b0; dmem_resp = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_wb(input string nm, input logic we, input logic [4:0] rd, input logic [31:0] d);
        chk({nm, "_we"}, 32'(o_regf_we), 32'(we));
        if (we) begin
            chk({nm, "_rd"}, 32'(o_rd_addr), 32'(rd));
            chk({nm, "_data"}, o_write_data, d);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_wb("rst", 1'b0, 5'd0, 32'd0);
        chk("rst_rd", 32'(o_rd_addr), 32'd0);
        chk("rst_data", o_write_data, 32'd0);
        chk("rst_busy", o_busy_rd, 32'd0);
        chk("rst_cnt", 32'(o_outstanding), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        rst_n = 1'b1;

        cycle(1, 1, 5'd5, 3'd2, 2'd0, 0, 32'h0);
        chk("lw_busy5_pending", 32'(o_busy_rd[5]), 32'd1);
        cycle(0, 0, 5'd0, 3'd0, 2'd0, 1, 32'hDEADBEEF);
        chk_wb("lw", 1'b1, 5'd5, 32'hDEADBEEF);
        chk("lw_busy5_clear", 32'(o_busy_rd[5]), 32'd0);

        cycle(1, 1, 5'd1, 3'd0, 2'd3, 0, 32'h0);
        cycle(1, 1, 5'd2, 3'd4, 2'd3, 0, 32'h0);
        cycle(1, 1, 5'd3, 3'd1, 2'd2, 0, 32'h0);
        cycle(1, 1, 5'd4, 3'd5, 2'd2, 0, 32'h0);
        chk("full_ready", 32'(iss_ready), 32'd0);
        chk("full_cnt", 32'(o_outstanding), 32'd4);
        cycle(1, 1, 5'd9, 3'd2, 2'd0, 1, 32'h80FFFF00);
        chk_wb("lb", 1'b1, 5'd1, 32'hFFFFFF80);
        chk("full_refused_cnt", 32'(o_outstanding), 32'd3);
        cycle(0, 0, 5'd0, 3'd0, 2'd0, 1, 32'h80FFFF00);
        chk_wb("lbu", 1'b1, 5'd2, 32'h00000080);
        cycle(0, 0, 5'd0, 3'd0, 2'd0, 1, 32'h80FFFF00);
        chk_wb("lh", 1'b1, 5'd3, 32'hFFFF80FF);
        cycle(0, 0, 5'd0, 3'd0, 2'd0, 1, 32'h80FFFF00);
        chk_wb("lhu", 1'b1, 5'd4, 32'h000080FF);
        chk("drain_cnt", 32'(o_outstanding), 32'd0);

        cycle(1, 1, 5'd7, 3'd2, 2'd0, 0, 32'h0);
        cycle(1, 0, 5'd7, 3'd2, 2'd0, 0, 32'h0);
        cycle(1, 1, 5'd7, 3'd2, 2'd0, 0, 32'h0);
        cycle(0, 0, 5'd0, 3'd0, 2'd0, 1, 32'h11);
        chk_wb("dup1", 1'b1, 5'd7, 32'h11);
        chk("dup1_busy7", 32'(o_busy_rd[7]), 32'd1);
        cycle(0, 0, 5'd0, 3'd0, 2'd0, 1, 32'h22);
        chk_wb("store", 1'b0, 5'd0, 32'h0);
        chk("store_busy7", 32'(o_busy_rd[7]), 32'd1);
        cycle(0, 0, 5'd0, 3'd0, 2'd0, 1, 32'h33);
        chk_wb("dup2", 1'b1, 5'd7, 32'h33);
        chk("dup2_busy7", 32'(o_busy_rd[7]), 32'd0);

        chk("err_clean", 32'(o_err), 32'd0);
        cycle(0, 0, 5'd0, 3'd0, 2'd0, 1, 32'h55);
        chk_wb("empty_resp", 1'b0, 5'd0, 32'h0);
        chk("empty_resp_err", 32'(o_err), 32'd1);
        apply_reset();
        chk("err_after_rst", 32'(o_err), 32'd0);
        cycle(1, 1, 5'd6, 3'd7, 2'd0, 0, 32'h0);
        cycle(0, 0, 5'd0, 3'd0, 2'd0, 1, 32'h1234);
        chk_wb("illegal", 1'b0, 5'd0, 32'h0);
        chk("illegal_data", o_write_data, 32'h0);
        chk("illegal_err", 32'(o_err), 32'd1);
        cycle(1, 1, 5'd0, 3'd2, 2'd0, 0, 32'h0);
        chk("x0_busy", o_busy_rd, 32'h0);
        cycle(0, 0, 5'd0, 3'd0, 2'd0, 1, 32'h77);
        chk_wb("x0", 1'b0, 5'd0, 32'h0);

        apply_reset();
        for (int n = 0; n < 400; n++) begin
            logic [2:0] f3;
            f3 = 3'($urandom_range(0, 7));
            if ((f3 == 3 || f3 == 6 || f3 == 7) && $urandom_range(0, 3) != 0) f3 = 3'd2;
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                  f3, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) != 0), $urandom);
        end
        for (int k = 0; k < 8 && mq.size() != 0; k++) cycle(0, 0, 5'd0, 3'd0, 2'd0, 1, $urandom);
        chk("rand_drain_cnt", 32'(o_outstanding), 32'd0);

        cycle(1, 1, 5'd10, 3'd2, 2'd0, 0, 32'h0);
        cycle(1, 1, 5'd11, 3'd2, 2'd0, 0, 32'h0);
        cycle(1, 1, 5'd12, 3'd2, 2'd0, 0, 32'h0);
        cycle(1, 1, 5'd13, 3'd2, 2'd0, 0, 32'h0);
        cycle(0, 0, 5'd0, 3'd0, 2'd0, 1, 32'hCAFEF00D);
        chk_wb("pre_rst", 1'b1, 5'd10, 32'hCAFEF00D);
        chk("pre_rst_cnt", 32'(o_outstanding), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(o_regf_we), 32'd0);
        chk("arst_rd", 32'(o_rd_addr), 32'd0);
        chk("arst_data", o_write_data, 32'd0);
        chk("arst_busy", o_busy_rd, 32'd0);
        chk("arst_cnt", 32'(o_outstanding), 32'd0);
        chk("arst_err", 32'(o_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_cnt", 32'(o_outstanding), 32'd0);
        chk("post_rst_ready", 32'(iss_ready), 32'd1);

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL leftover_writes: got %0d unmatched, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
